cascade_stage_scheduler: RTL and testbench

- Sequences the per-stage Haar cascade classifiers for one integral-image window at a time.
- Loads the window into all stage FIFOs, then starts stages strictly in order 0..NUM_STAGE-1, one at a time.
- Exits early on the first stage reject and reports face/non-face plus the reject stage.
- Sits between the integral-image window generator and the stage classifier array; replaces ad-hoc combinational stage counting.

---
 rtl/cascade_stage_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_cascade_stage_scheduler.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cascade_stage_scheduler.sv
// cascade_stage_scheduler
// Runs the Haar cascade for one integral-image window at a time. It broadcasts
// the window copy, starts the stages in order with a one-hot pulse, stops at
// the first reject or on a per-stage watchdog expiry, and holds the verdict
// until the consumer takes it.
//
// Optional feature macro: CASCADE_STATS_EN
//   defined   -> saturating counters for accepted windows and reported faces
//   undefined -> o_window_count / o_face_count are tied to zero
//
// Handshakes: a window transfers on a cycle where i_window_valid and
// o_window_ready are both 1; a result transfers on a cycle where
// o_result_valid and i_result_ready are both 1. Once raised, o_result_valid and
// its payload stay unchanged until that transfer. Stage done/pass are pulses
// and only the bit of the currently active stage is looked at.
module cascade_stage_scheduler #(
    parameter int NUM_STAGE      = 10,
    parameter int DATA_WIDTH_8   = 8,
    parameter int DATA_WIDTH_16  = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_window_valid,
    output logic                     o_window_ready,
    output logic                     o_en_copy,
    output logic [NUM_STAGE-1:0]     o_calculate,
    input  logic [NUM_STAGE-1:0]     i_stage_done,
    input  logic [NUM_STAGE-1:0]     i_stage_pass,
    output logic                     o_result_valid,
    input  logic                     i_result_ready,
    output logic                     o_face,
    output logic [DATA_WIDTH_8-1:0]  o_reject_stage,
    output logic                     o_timeout,
    output logic                     o_busy,
    output logic [DATA_WIDTH_16-1:0] o_window_count,
    output logic [DATA_WIDTH_16-1:0] o_face_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COPY,
        S_START,
        S_WAIT,
        S_REPORT
    } state_t;

    localparam logic [DATA_WIDTH_8-1:0]  LAST_STAGE = DATA_WIDTH_8'(NUM_STAGE - 1);
    localparam logic [DATA_WIDTH_8-1:0]  ALL_PASSED = DATA_WIDTH_8'(NUM_STAGE);
    localparam logic [DATA_WIDTH_16-1:0] TIMER_LAST = DATA_WIDTH_16'(TIMEOUT_CYCLES - 1);

    state_t                    state;
    logic [DATA_WIDTH_8-1:0]   stage;
    logic [DATA_WIDTH_16-1:0]  timer;
    logic                      cur_done;
    logic                      cur_pass;

    // One-hot start vector for a given stage index.
    function automatic logic [NUM_STAGE-1:0] stage_onehot(input logic [DATA_WIDTH_8-1:0] idx);
        logic [NUM_STAGE-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_STAGE; i++) begin
            if (idx == DATA_WIDTH_8'(i)) begin
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

    // Select the done/pass bits of the active stage only; others are ignored.
    always_comb begin
        cur_done = 1'b0;
        cur_pass = 1'b0;
        for (int i = 0; i < NUM_STAGE; i++) begin
            if (stage == DATA_WIDTH_8'(i)) begin
                cur_done = i_stage_done[i];
                cur_pass = i_stage_pass[i];
            end
        end
    end

    // Cascade sequencing FSM with registered outputs.
    // The watchdog is cleared on the edge that raises the start pulse and then
    // counts every cycle of START and WAIT, so expiry lands TIMEOUT_CYCLES-1
    // cycles after the start pulse and the verdict shows TIMEOUT_CYCLES after it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            stage          <= '0;
            timer          <= '0;
            o_window_ready <= 1'b1;
            o_en_copy      <= 1'b0;
            o_calculate    <= '0;
            o_result_valid <= 1'b0;
            o_face         <= 1'b0;
            o_reject_stage <= '0;
            o_timeout      <= 1'b0;
        end else begin
            o_en_copy   <= 1'b0;
            o_calculate <= '0;
            case (state)
                S_IDLE: begin
                    if (i_window_valid) begin
                        state          <= S_COPY;
                        stage          <= '0;
                        o_window_ready <= 1'b0;
                        o_en_copy      <= 1'b1;
                    end
                end
                S_COPY: begin
                    state       <= S_START;
                    o_calculate <= stage_onehot(stage);
                    timer       <= '0;
                end
                S_START: begin
                    state <= S_WAIT;
                    timer <= timer + DATA_WIDTH_16'(1);
                end
                S_WAIT: begin
                    if (cur_done && cur_pass && stage == LAST_STAGE) begin
                        state          <= S_REPORT;
                        o_result_valid <= 1'b1;
                        o_face         <= 1'b1;
                        o_reject_stage <= ALL_PASSED;
                        o_timeout      <= 1'b0;
                    end else if (cur_done && cur_pass) begin
                        state       <= S_START;
                        stage       <= stage + DATA_WIDTH_8'(1);
                        o_calculate <= stage_onehot(stage + DATA_WIDTH_8'(1));
                        timer       <= '0;
                    end else if (cur_done) begin
                        state          <= S_REPORT;
                        o_result_valid <= 1'b1;
                        o_face         <= 1'b0;
                        o_reject_stage <= stage;
                        o_timeout      <= 1'b0;
                    end else if (timer == TIMER_LAST) begin
                        state          <= S_REPORT;
                        o_result_valid <= 1'b1;
                        o_face         <= 1'b0;
                        o_reject_stage <= stage;
                        o_timeout      <= 1'b1;
                    end else begin
                        timer <= timer + DATA_WIDTH_16'(1);
                    end
                end
                S_REPORT: begin
                    if (i_result_ready) begin
                        state          <= S_IDLE;
                        o_result_valid <= 1'b0;
                        o_face         <= 1'b0;
                        o_reject_stage <= '0;
                        o_timeout      <= 1'b0;
                        o_window_ready <= 1'b1;
                    end
                end
                default: begin
                    state          <= S_IDLE;
                    o_window_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_busy = (state != S_IDLE);

`ifdef CASCADE_STATS_EN
    localparam logic [DATA_WIDTH_16-1:0] COUNT_MAX = '1;

    logic window_accept;
    logic face_entry;

    assign window_accept = (state == S_IDLE) && i_window_valid;
    assign face_entry    = (state == S_WAIT) && cur_done && cur_pass && (stage == LAST_STAGE);

    // Saturating window and face counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_window_count <= '0;
            o_face_count   <= '0;
        end else begin
            if (window_accept && o_window_count != COUNT_MAX) begin
                o_window_count <= o_window_count + DATA_WIDTH_16'(1);
            end
            if (face_entry && o_face_count != COUNT_MAX) begin
                o_face_count <= o_face_count + DATA_WIDTH_16'(1);
            end
        end
    end
`else
    assign o_window_count = '0;
    assign o_face_count   = '0;
`endif

endmodule

// File: tb/tb_cascade_stage_scheduler.sv
// Bench for cascade_stage_scheduler: directed vector table, random windows
// against a cascade reference model, hold/re-accept and mid-window reset.
module tb_cascade_stage_scheduler;

    localparam int NS  = 3;
    localparam int TMO = 16;

    // clock / reset
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          i_window_valid = 1'b0;
    logic          o_window_ready;
    logic          o_en_copy;
    logic [NS-1:0] o_calculate;
    logic [NS-1:0] i_stage_done = '0;
    logic [NS-1:0] i_stage_pass = '0;
    logic          o_result_valid;
    logic          i_result_ready = 1'b0;
    logic          o_face;
    logic [7:0]    o_reject_stage;
    logic          o_timeout;
    logic          o_busy;
    logic [15:0]   o_window_count;
    logic [15:0]   o_face_count;

    cascade_stage_scheduler #(
        .NUM_STAGE(NS), .DATA_WIDTH_8(8), .DATA_WIDTH_16(16), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .i_window_valid(i_window_valid), .o_window_ready(o_window_ready),
        .o_en_copy(o_en_copy), .o_calculate(o_calculate),
        .i_stage_done(i_stage_done), .i_stage_pass(i_stage_pass),
        .o_result_valid(o_result_valid), .i_result_ready(i_result_ready),
        .o_face(o_face), .o_reject_stage(o_reject_stage), .o_timeout(o_timeout),
        .o_busy(o_busy), .o_window_count(o_window_count), .o_face_count(o_face_count)
    );

`ifdef CASCADE_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    // expected result packing: {face, timeout, reject_stage[7:0], latency[15:0]}
    logic [25:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int exp_wc = 0;
    int exp_fc = 0;

    // dv = {d2,d1,d0}: cycles from start pulse to done, 0 = never
    typedef struct packed {
        logic [23:0] dv;
        logic [2:0]  p;
        logic        spur;
        logic [7:0]  hold;
        logic        hv;
        logic        face;
        logic        tmo;
        logic [7:0]  rej;
        logic [15:0] lat;
        logic [7:0]  ns;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Reference cascade: stage k starts at time t, a done at t+d (1..TMO-1)
    // decides or moves on at t+d+1; otherwise the watchdog reports at t+TMO.
    function automatic logic [25:0] model(input logic [23:0] dv, input logic [2:0] p, output int nst);
        int t;
        int d;
        t = 2;
        nst = 0;
        for (int k = 0; k < NS; k++) begin
            d = int'(dv[k*8 +: 8]);
            nst++;
            if (d >= 1 && d <= TMO - 1) begin
                if (!p[k]) return {1'b0, 1'b0, 8'(k), 16'(t + d + 1)};
                if (k == NS - 1) return {1'b1, 1'b0, 8'(NS), 16'(t + d + 1)};
                t = t + d + 1;
            end else begin
                return {1'b0, 1'b1, 8'(k), 16'(t + TMO)};
            end
        end
        return '0;
    endfunction

    task automatic check_counts(input string name);
        chk({name, "_window_count"}, 32'(o_window_count), STATS_ON ? 32'(exp_wc) : 32'd0);
        chk({name, "_face_count"}, 32'(o_face_count), STATS_ON ? 32'(exp_fc) : 32'd0);
    endtask

    task automatic check_idle(input string name);
        chk({name, "_window_ready"}, 32'(o_window_ready), 32'd1);
        chk({name, "_en_copy"}, 32'(o_en_copy), 32'd0);
        chk({name, "_calculate"}, 32'(o_calculate), 32'd0);
        chk({name, "_result_valid"}, 32'(o_result_valid), 32'd0);
        chk({name, "_result"}, {22'd0, o_face, o_timeout, o_reject_stage}, 32'd0);
        chk({name, "_busy"}, 32'(o_busy), 32'd0);
    endtask

    // Driver: offer one window, answer start pulses, check the result.
    // rst_stage >= 0 instead asserts reset while that stage is waiting.
    task automatic run_window(input vec_t v, input logic [25:0] e, input int nst, input int rst_stage);
        int t0, next_stg, sst, k, d, wn;
        bit finished;
        logic [25:0] exp;
        if (rst_stage < 0) exp_q.push_back(e);
        wn = 0;
        while (!o_window_ready && wn < 60) begin
            step();
            wn++;
        end
        chk("window_ready_wait", 32'(o_window_ready), 32'd1);
        i_window_valid = 1'b1;
        t0 = cyc;
        exp_wc++;
        next_stg = 0;
        sst = -1;
        finished = 1'b0;
        while (!finished && cyc - t0 < 200) begin
            step();
            i_window_valid = v.hv;
            i_stage_done = '0;
            i_stage_pass = '0;
            chk("en_copy_timing", 32'(o_en_copy), 32'(cyc == t0 + 1));
            if (o_calculate != '0) begin
                chk("calc_onehot", 32'(o_calculate), 32'(1 << next_stg));
                if (next_stg == 0) chk("first_start", 32'(cyc - t0), 32'd2);
                sst = cyc;
                next_stg++;
            end
            if (o_result_valid) begin
                exp = exp_q.pop_front();
                chk("result", {6'd0, o_face, o_timeout, o_reject_stage, 16'(cyc - t0)}, {6'd0, exp});
                chk("starts", 32'(next_stg), 32'(nst));
                chk("busy_report", 32'(o_busy), 32'd1);
                if (exp[25]) exp_fc++;
                for (int h = 0; h < int'(v.hold); h++) begin
                    step();
                    chk("hold_stable", {21'd0, o_result_valid, o_window_ready, o_face, o_timeout, o_reject_stage},
                        {21'd0, 1'b1, 1'b0, exp[25:16]});
                end
                i_result_ready = 1'b1;
                step();
                i_result_ready = 1'b0;
                check_idle("after_ready");
                check_counts("after_ready");
                if (v.hv) begin
                    step();
                    i_window_valid = 1'b0;
                    chk("reaccept_en_copy", 32'(o_en_copy), 32'd1);
                    exp_wc++;
                    // let the unattended window time out and consume it
                    i_result_ready = 1'b1;
                    wn = 0;
                    while (!o_window_ready && wn < 60) begin
                        step();
                        wn++;
                    end
                    i_result_ready = 1'b0;
                    chk("drain", 32'(o_window_ready), 32'd1);
                end
                finished = 1'b1;
            end else if (sst >= 0) begin
                k = next_stg - 1;
                d = int'(v.dv[k*8 +: 8]);
                if (d != 0 && cyc == sst + d) begin
                    i_stage_done[k] = 1'b1;
                    i_stage_pass[k] = v.p[k];
                end
                if (v.spur && k == 0 && cyc == sst + 1) begin
                    i_stage_done[2] = 1'b1;
                    i_stage_pass[2] = 1'b0;
                end
                if (rst_stage == k && cyc == sst + 2) begin
                    reset = 1'b1;
                    i_stage_done = '0;
                    i_stage_pass = '0;
                    step();
                    reset = 1'b0;
                    exp_wc = 0;
                    exp_fc = 0;
                    check_idle("mid_reset");
                    check_counts("mid_reset");
                    finished = 1'b1;
                end
            end
        end
        i_window_valid = 1'b0;
        i_stage_done = '0;
        i_stage_pass = '0;
        chk("window_budget", 32'(finished), 32'd1);
    endtask

    initial begin
        vec_t v;
        logic [25:0] e;
        int nst, r;

        //                dv                      p       spur hold  hv face tmo rej lat ns
        tbl[0] = '{{8'd1, 8'd1, 8'd1},  3'b111, 1'b0, 8'd0,  1'b0, 1'b1, 1'b0, 8'd3, 16'd8,  8'd3};
        tbl[1] = '{{8'd1, 8'd1, 8'd1},  3'b101, 1'b0, 8'd1,  1'b0, 1'b0, 1'b0, 8'd1, 16'd6,  8'd2};
        tbl[2] = '{{8'd0, 8'd0, 8'd0},  3'b111, 1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 8'd0, 16'd18, 8'd1};
        tbl[3] = '{{8'd1, 8'd1, 8'd1},  3'b111, 1'b1, 8'd2,  1'b0, 1'b1, 1'b0, 8'd3, 16'd8,  8'd3};
        tbl[4] = '{{8'd5, 8'd2, 8'd3},  3'b111, 1'b0, 8'd0,  1'b0, 1'b1, 1'b0, 8'd3, 16'd15, 8'd3};
        tbl[5] = '{{8'd0, 8'd0, 8'd15}, 3'b110, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'd0, 16'd18, 8'd1};
        tbl[6] = '{{8'd0, 8'd0, 8'd1},  3'b111, 1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 8'd1, 16'd20, 8'd2};
        tbl[7] = '{{8'd0, 8'd0, 8'd16}, 3'b111, 1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 8'd0, 16'd18, 8'd1};
        tbl[8] = '{{8'd1, 8'd1, 8'd1},  3'b111, 1'b0, 8'd10, 1'b1, 1'b1, 1'b0, 8'd3, 16'd8,  8'd3};

        // reset state
        reset = 1'b1;
        step();
        step();
        check_idle("reset");
        check_counts("reset");
        reset = 1'b0;
        step();
        check_idle("post_reset");

        // directed table
        for (int i = 0; i < 9; i++) begin
            run_window(tbl[i], {tbl[i].face, tbl[i].tmo, tbl[i].rej, tbl[i].lat}, int'(tbl[i].ns), -1);
        end

        // random windows against the reference model
        for (int i = 0; i < 40; i++) begin
            v = '0;
            for (int k = 0; k < NS; k++) begin
                r = $urandom_range(0, 9);
                v.dv[k*8 +: 8] = (r == 0) ? 8'($urandom_range(13, 17)) :
                                 (r == 1) ? 8'd0 : 8'($urandom_range(1, 3));
                v.p[k] = ($urandom_range(0, 5) != 0);
            end
            v.spur = 1'($urandom_range(0, 1));
            v.hold = 8'($urandom_range(0, 3));
            e = model(v.dv, v.p, nst);
            run_window(v, e, nst, -1);
        end

        // reset while stage 2 is waiting
        v = '0;
        v.dv = {8'd0, 8'd1, 8'd1};
        v.p = 3'b111;
        run_window(v, '0, 0, 2);

        // recovery after reset
        run_window(tbl[0], {tbl[0].face, tbl[0].tmo, tbl[0].rej, tbl[0].lat}, 3, -1);
        check_counts("final");
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // absolute time bound
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
